// File: rtl/fetch_arb_pkg.sv
// Shared constants and helpers for the instruction fetch arbiter.
package fetch_arb_pkg;

  // Default sizing; instances may override through module parameters.
  localparam int unsigned NUM_REQ_DEF    = 4;
  localparam int unsigned ADDR_WIDTH_DEF = 8;
  localparam int unsigned DATA_WIDTH_DEF = 16;

  // Requester index width for the default configuration.
  localparam int unsigned REQ_IDX_W = (NUM_REQ_DEF > 1) ? $clog2(NUM_REQ_DEF) : 1;

  typedef logic [REQ_IDX_W-1:0] req_idx_t;

  // Successor of idx in a ring of n requesters.
  function automatic int next_idx(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

  // Requester index reached after stepping k places from start around a ring of n.
  function automatic int ring_idx(input int start, input int k, input int n);
    return (start + k) % n;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational round-robin picker: finds the first two asserted requests
// scanning upward from rr_ptr, wrapping modulo NUM_REQ.
module rr_pick2
  import fetch_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   sel1,
  output logic               sel1_valid,
  output logic [IDX_W-1:0]   sel2,
  output logic               sel2_valid
);

  // Walk the ring once from rr_ptr; the first hit feeds port 1, the second port 2.
  always_comb begin
    int idx;
    sel1       = '0;
    sel2       = '0;
    sel1_valid = 1'b0;
    sel2_valid = 1'b0;
    idx        = 0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      idx = ring_idx(int'(rr_ptr), k, int'(NUM_REQ));
      if (req[idx]) begin
        if (!sel1_valid) begin
          sel1_valid = 1'b1;
          sel1       = IDX_W'(idx);
        end else if (!sel2_valid) begin
          sel2_valid = 1'b1;
          sel2       = IDX_W'(idx);
        end
      end
    end
  end

endmodule

// File: rtl/instruction_fetch_arbiter.sv
// Shares the two combinational read ports of the instruction memory between
// NUM_REQ fetch requesters. Up to two requesters are granted per cycle in
// round-robin order; their instruction words are registered and returned one
// cycle later with a single-cycle valid pulse.
module instruction_fetch_arbiter
  import fetch_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = NUM_REQ_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [NUM_REQ*DATA_WIDTH-1:0] rsp_data,
  output logic [ADDR_WIDTH-1:0]         address_1,
  output logic [ADDR_WIDTH-1:0]         address_2,
  input  logic [DATA_WIDTH-1:0]         read_data_1,
  input  logic [DATA_WIDTH-1:0]         read_data_2
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDX_W-1:0]            rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]          rsp_valid_q, rsp_valid_d;
  logic [NUM_REQ*DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic [IDX_W-1:0] sel1, sel2;
  logic             sel1_valid, sel2_valid;
  logic [IDX_W-1:0] last_sel;

  rr_pick2 #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick2 (
    .req        (req),
    .rr_ptr     (rr_ptr_q),
    .sel1       (sel1),
    .sel1_valid (sel1_valid),
    .sel2       (sel2),
    .sel2_valid (sel2_valid)
  );

  // Grant vector; forced low during reset so no requester sees a spurious grant.
  always_comb begin
    grant = '0;
    if (!reset) begin
      if (sel1_valid) grant[sel1] = 1'b1;
      if (sel2_valid) grant[sel2] = 1'b1;
    end
  end

  // Memory port address muxes; an unused port parks at address 0.
  always_comb begin
    address_1 = '0;
    address_2 = '0;
    if (sel1_valid) address_1 = req_addr[int'(sel1)*ADDR_WIDTH +: ADDR_WIDTH];
    if (sel2_valid) address_2 = req_addr[int'(sel2)*ADDR_WIDTH +: ADDR_WIDTH];
  end

  // Next pointer: one past the last granted index so both grantees move to the back.
  always_comb begin
    last_sel = sel2_valid ? sel2 : sel1;
    rr_ptr_d = rr_ptr_q;
    if (sel1_valid) rr_ptr_d = IDX_W'(next_idx(int'(last_sel), int'(NUM_REQ)));
  end

  // Response capture: granted slots load fresh data, the rest keep theirs.
  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (sel1_valid) begin
      rsp_valid_d[sel1]                                = 1'b1;
      rsp_data_d[int'(sel1)*DATA_WIDTH +: DATA_WIDTH]  = read_data_1;
    end
    if (sel2_valid) begin
      rsp_valid_d[sel2]                                = 1'b1;
      rsp_data_d[int'(sel2)*DATA_WIDTH +: DATA_WIDTH]  = read_data_2;
    end
  end

  // State registers; reset discards in-flight fetches and pending pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_instruction_fetch_arbiter.sv
// Scoreboard bench for instruction_fetch_arbiter with a 4-word instruction memory.
module tb_instruction_fetch_arbiter;

  localparam int N  = 4;
  localparam int AW = 2;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N-1:0]    grant;
  logic [N-1:0]    rsp_valid;
  logic [N*DW-1:0] rsp_data;
  logic [AW-1:0]   address_1, address_2;
  logic [DW-1:0]   read_data_1, read_data_2;

  logic [DW-1:0] mem [4];
  initial begin
    mem[0] = 8'hA0; mem[1] = 8'hA1; mem[2] = 8'hA2; mem[3] = 8'hA3;
  end
  assign read_data_1 = mem[address_1];
  assign read_data_2 = mem[address_2];

  instruction_fetch_arbiter #(
    .NUM_REQ    (N),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_addr    (req_addr),
    .grant       (grant),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .address_1   (address_1),
    .address_2   (address_2),
    .read_data_1 (read_data_1),
    .read_data_2 (read_data_2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  typedef struct packed {
    int              due;
    logic [N-1:0]    mask;
    logic [N*DW-1:0] data;
  } exp_t;

  exp_t         sb[$];
  int           m_ptr = 0;
  logic [N-1:0] last_grant = '0;
  int           resp_cnt [N];
  int           wait_cnt [N];

  function automatic logic [AW-1:0] addr_of(input int i);
    logic [N*AW-1:0] a;
    a = req_addr;
    return a[i*AW +: AW];
  endfunction

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    req_addr[i*AW +: AW] = a;
  endtask

  // One clock: evaluate the model at the falling edge, then step past the rising edge.
  task automatic cycle();
    int           order[$];
    exp_t         e;
    logic [N-1:0] eg;
    logic [AW-1:0] ea1, ea2;
    @(negedge clk);
    if (reset) begin
      check("grant_in_reset", 32'(grant), 32'(0));
      m_ptr = 0;
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    end else begin
      for (int k = 0; k < N; k++)
        if (req[(m_ptr + k) % N]) order.push_back((m_ptr + k) % N);
      eg = '0; ea1 = '0; ea2 = '0;
      e.due = cyc + 1; e.data = '0;
      if (order.size() >= 1) begin
        eg[order[0]] = 1'b1;
        ea1 = addr_of(order[0]);
        e.data[order[0]*DW +: DW] = mem[ea1];
      end
      if (order.size() >= 2) begin
        eg[order[1]] = 1'b1;
        ea2 = addr_of(order[1]);
        e.data[order[1]*DW +: DW] = mem[ea2];
      end
      e.mask = eg;
      check("grant", 32'(grant), 32'(eg));
      check("address_1", 32'(address_1), 32'(ea1));
      check("address_2", 32'(address_2), 32'(ea2));
      if (order.size() > 0) begin
        sb.push_back(e);
        m_ptr = (order[order.size() >= 2 ? 1 : 0] + 1) % N;
      end
      // No continuously requesting requester may wait more than one cycle (N=4).
      for (int i = 0; i < N; i++) begin
        if (req[i] && !grant[i]) begin
          wait_cnt[i]++;
          check("fair_wait", 32'(wait_cnt[i] <= 1), 32'(1));
        end else begin
          wait_cnt[i] = 0;
        end
      end
    end
    last_grant = grant;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sb.delete();
    req = '0;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  // Monitor: every falling edge, the response due this cycle (if any) must appear.
  initial begin
    exp_t e;
    for (int i = 0; i < N; i++) resp_cnt[i] = 0;
    forever begin
      @(negedge clk);
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        check("rsp_valid", 32'(rsp_valid), 32'(e.mask));
        for (int i = 0; i < N; i++) begin
          if (e.mask[i]) begin
            check("rsp_data", 32'(rsp_data[i*DW +: DW]), 32'(e.data[i*DW +: DW]));
            resp_cnt[i]++;
          end
        end
      end else begin
        check("rsp_valid_idle", 32'(rsp_valid), 32'(0));
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    // Reset with requests asserted: no grants may leak out.
    req = 4'b1111;
    cycle();
    cycle();
    req = '0;
    reset = 1'b0;
    cycle();

    // Single requester.
    req = 4'b0001; set_addr(0, 2'd2);
    cycle();
    check("single_grant", 32'(last_grant), 32'(4'b0001));
    req = '0;
    cycle(); cycle();

    // Two requesters in the same cycle.
    req = 4'b0011; set_addr(0, 2'd1); set_addr(1, 2'd3);
    cycle();
    check("dual_grant", 32'(last_grant), 32'(4'b0011));
    req = '0;
    cycle(); cycle();

    // All four held high from rr_ptr=0: alternating pairs.
    do_reset();
    for (int i = 0; i < N; i++) resp_cnt[i] = 0;
    for (int i = 0; i < N; i++) set_addr(i, AW'(i));
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("rr_sequence", 32'(last_grant), (k % 2 == 0) ? 32'h3 : 32'hC);
    end
    req = '0;
    cycle(); cycle();
    for (int i = 0; i < N; i++) check("resp_count", 32'(resp_cnt[i]), 32'd2);

    // Same address on both ports.
    req = 4'b0101; set_addr(0, 2'd0); set_addr(2, 2'd0);
    cycle();
    check("same_addr_grant", 32'(last_grant), 32'(4'b0101));
    req = '0;
    cycle(); cycle();

    // Reset while a response pulse is pending.
    req = 4'b1111;
    cycle();
    check("pulse_before_reset", 32'(rsp_valid), 32'(sb[0].mask));
    reset = 1'b1;
    sb.delete();
    #1;
    check("rsp_valid_async_clear", 32'(rsp_valid), 32'(0));
    check("grant_async_clear", 32'(grant), 32'(0));
    cycle(); cycle();
    reset = 1'b0;
    req = 4'b1000; set_addr(3, 2'd1);
    cycle();
    check("post_reset_grant", 32'(last_grant), 32'(4'b1000));
    req = '0;
    cycle(); cycle();

    // Randomised traffic with requesters honouring the hold-until-granted rule.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] || last_grant[i]) begin
          req[i] = ($urandom_range(0, 99) < 70);
          set_addr(i, AW'($urandom_range(0, 3)));
        end
      end
      cycle();
    end
    req = '0;
    cycle(); cycle(); cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
